// File: rtl/k16_alu_pkg.sv
// Shared K16 ALU encodings and the multiply sequencer state type.
// Defining K16_MUL_SIGNED_EN adds the negation states used for two's-complement multiplies.
package k16_alu_pkg;

  localparam logic [1:0] ALU_OP   = 2'b00;
  localparam logic [1:0] SHIFT_OP = 2'b01;
  localparam logic [1:0] LOAD_OP  = 2'b10;

  // SBC and ROR share a code; the operation type tells them apart.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_SBC = 3'b011;
  localparam logic [2:0] ALU_ROR = 3'b011;

`ifdef K16_MUL_SIGNED_EN
  typedef enum logic [3:0] {
    ST_IDLE, ST_ADD, ST_SHA, ST_SHQ, ST_DONE,
    ST_NEGM, ST_NEGQ, ST_NEGL, ST_NEGH
  } mul_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_ADD, ST_SHA, ST_SHQ, ST_DONE
  } mul_state_t;
`endif

endpackage

// File: rtl/k16_mul_seq.sv
// Shift-and-add 16x16 multiplier that borrows the shared K16 ALU while busy.
// Defining K16_MUL_SIGNED_EN adds the signed_op port and the sign-fixup states.
module k16_mul_seq
  import k16_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITERS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
`ifdef K16_MUL_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] alu_operand1,
  output logic [WIDTH-1:0] alu_operand2,
  output logic             alu_carry_in,
  output logic [1:0]       alu_operation_type,
  output logic [2:0]       alu_operation,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry_out,
  input  logic             alu_zero_out,
  input  logic             alu_negative_out
);

  mul_state_t       state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] mcand;
  logic             carry;
  logic [4:0]       count;
  logic             unused_flags;

`ifdef K16_MUL_SIGNED_EN
  logic signed_mode;
  logic negate_result;
`endif

  assign unused_flags = alu_zero_out ^ alu_negative_out;

  // ALU drive is purely combinational so the result lands on the same edge.
  always_comb begin
    alu_operand1       = '0;
    alu_operand2       = '0;
    alu_carry_in       = 1'b0;
    alu_operation_type = ALU_OP;
    alu_operation      = ALU_ADD;
    case (state)
      ST_ADD: begin
        alu_operand1 = acc;
        alu_operand2 = mcand;
      end
      ST_SHA: begin
        alu_operation_type = SHIFT_OP;
        alu_operation      = ALU_ROR;
        alu_operand1       = acc;
        alu_carry_in       = carry;
      end
      ST_SHQ: begin
        alu_operation_type = SHIFT_OP;
        alu_operation      = ALU_ROR;
        alu_operand1       = mq;
        alu_carry_in       = carry;
      end
`ifdef K16_MUL_SIGNED_EN
      ST_NEGM: begin
        alu_operation = ALU_SUB;
        alu_operand2  = mcand;
      end
      ST_NEGQ, ST_NEGL: begin
        alu_operation = ALU_SUB;
        alu_operand2  = mq;
      end
      ST_NEGH: begin
        alu_operation = ALU_SBC;
        alu_operand2  = acc;
        alu_carry_in  = carry;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      acc        <= '0;
      mq         <= '0;
      mcand      <= '0;
      carry      <= 1'b0;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      product_hi <= '0;
      product_lo <= '0;
`ifdef K16_MUL_SIGNED_EN
      signed_mode   <= 1'b0;
      negate_result <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= multiplicand;
            mq    <= multiplier;
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
`ifdef K16_MUL_SIGNED_EN
            signed_mode   <= signed_op;
            negate_result <= signed_op & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            state         <= signed_op ? ST_NEGM : ST_ADD;
`else
            state <= ST_ADD;
`endif
          end
        end
        ST_ADD: begin
          if (mq[0]) begin
            acc   <= alu_result;
            carry <= alu_carry_out;
          end else begin
            carry <= 1'b0;
          end
          state <= ST_SHA;
        end
        ST_SHA: begin
          acc   <= alu_result;
          carry <= alu_carry_out;
          state <= ST_SHQ;
        end
        ST_SHQ: begin
          mq    <= alu_result;
          count <= count + 5'd1;
          if (count == 5'(ITERS - 1)) begin
`ifdef K16_MUL_SIGNED_EN
            if (signed_mode) begin
              state <= ST_NEGL;
            end else begin
              product_hi <= acc;
              product_lo <= alu_result;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= ST_DONE;
            end
`else
            // Products load on the edge into DONE so they are valid alongside done.
            product_hi <= acc;
            product_lo <= alu_result;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= ST_DONE;
`endif
          end else begin
            state <= ST_ADD;
          end
        end
`ifdef K16_MUL_SIGNED_EN
        ST_NEGM: begin
          if (mcand[WIDTH-1]) mcand <= alu_result;
          state <= ST_NEGQ;
        end
        ST_NEGQ: begin
          if (mq[WIDTH-1]) mq <= alu_result;
          state <= ST_ADD;
        end
        ST_NEGL: begin
          carry <= alu_carry_out;
          if (negate_result) mq <= alu_result;
          state <= ST_NEGH;
        end
        ST_NEGH: begin
          if (negate_result) acc <= alu_result;
          product_hi <= negate_result ? alu_result : acc;
          product_lo <= mq;
          busy       <= 1'b0;
          done       <= 1'b1;
          state      <= ST_DONE;
        end
`endif
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_k16_mul_seq.sv
// Scoreboard bench for k16_mul_seq with a behavioural K16 ALU and a product/latency reference model.
// Exercises the default (unsigned) build.
module tb_k16_mul_seq;
  import k16_alu_pkg::*;

  localparam int LATENCY = 49;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        signed_op;
  logic        busy;
  logic        done;
  logic [15:0] product_hi;
  logic [15:0] product_lo;
  logic [15:0] alu_operand1;
  logic [15:0] alu_operand2;
  logic        alu_carry_in;
  logic [1:0]  alu_operation_type;
  logic [2:0]  alu_operation;
  logic [15:0] alu_result;
  logic        alu_carry_out;
  logic        alu_zero_out;
  logic        alu_negative_out;
  logic [16:0] alu_wide;

  typedef struct {
    logic [31:0] prod;
    int          acceptCycle;
  } exp_t;

  exp_t        sbq[$];
  int          cyc = 0;
  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] lastProd = '0;

  k16_mul_seq dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .multiplicand       (multiplicand),
    .multiplier         (multiplier),
`ifdef K16_MUL_SIGNED_EN
    .signed_op          (signed_op),
`endif
    .busy               (busy),
    .done               (done),
    .product_hi         (product_hi),
    .product_lo         (product_lo),
    .alu_operand1       (alu_operand1),
    .alu_operand2       (alu_operand2),
    .alu_carry_in       (alu_carry_in),
    .alu_operation_type (alu_operation_type),
    .alu_operation      (alu_operation),
    .alu_result         (alu_result),
    .alu_carry_out      (alu_carry_out),
    .alu_zero_out       (alu_zero_out),
    .alu_negative_out   (alu_negative_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural K16 ALU: add/subtract with a 17-bit carry/borrow, rotate right through carry.
  always_comb begin
    alu_wide      = '0;
    alu_result    = '0;
    alu_carry_out = 1'b0;
    if (alu_operation_type == SHIFT_OP && alu_operation == ALU_ROR) begin
      alu_result    = {alu_carry_in, alu_operand1[15:1]};
      alu_carry_out = alu_operand1[0];
    end else if (alu_operation_type == ALU_OP) begin
      case (alu_operation)
        ALU_ADD: alu_wide = {1'b0, alu_operand1} + {1'b0, alu_operand2} + {16'b0, alu_carry_in};
        ALU_SUB: alu_wide = {1'b0, alu_operand1} - {1'b0, alu_operand2};
        ALU_SBC: alu_wide = {1'b0, alu_operand1} - {1'b0, alu_operand2} - {16'b0, alu_carry_in};
        default: alu_wide = '0;
      endcase
      alu_result    = alu_wide[15:0];
      alu_carry_out = alu_wide[16];
    end
    alu_zero_out     = (alu_result == 16'h0000);
    alu_negative_out = alu_result[15];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding request in value and latency.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        checkOutput("product", {product_hi, product_lo}, e.prod);
        checkOutput("latency", 32'(cyc - e.acceptCycle + 1), 32'(LATENCY));
      end
    end
  end

  // One multiply; p1/p2 are cycles where a stray start is pulsed, rstAt aborts with reset.
  task automatic applyStimulus(input logic [15:0] m, input logic [15:0] q,
                               input int p1, input int p2, input int rstAt);
    bit   seen = 0;
    exp_t e;
    @(negedge clk);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start         = 1'b0;
    e.prod        = 32'(m) * 32'(q);
    e.acceptCycle = cyc;
    sbq.push_back(e);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start        = (k == p1) || (k == p2);
      multiplicand = 16'($urandom);
      multiplier   = 16'($urandom);
      if (k == 1)  checkOutput("busy_cycle1", {31'b0, busy}, 32'd1);
      if (k == 20) checkOutput("product_held", {product_hi, product_lo}, lastProd);
      if (k == 48) checkOutput("busy_cycle48", {31'b0, busy}, 32'd1);
      if (k == 49) checkOutput("busy_cycle49", {31'b0, busy}, 32'd0);
      if (k == rstAt) begin
        reset = 1'b1;
        #1;
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_done", {31'b0, done}, 32'd0);
        checkOutput("abort_product", {product_hi, product_lo}, 32'd0);
        sbq.delete();
        lastProd = '0;
        start    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        return;
      end
      if (done) begin
        seen     = 1;
        lastProd = e.prod;
        break;
      end
    end
    checkOutput("done_seen", {31'b0, seen}, 32'd1);
    if (start) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    signed_op    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_product", {product_hi, product_lo}, 32'd0);
    checkOutput("reset_alu_drive",
                {alu_operation_type, alu_operation, alu_carry_in, alu_operand1, alu_operand2[9:0]},
                32'd0);
    reset = 1'b0;

    applyStimulus(16'h0003, 16'h0005, 0, 0, 0);
    checkOutput("lo_3x5", {16'b0, product_lo}, 32'h0000_000F);
    applyStimulus(16'hFFFF, 16'hFFFF, 0, 0, 0);
    checkOutput("ffff_sq", {product_hi, product_lo}, 32'hFFFE_0001);
    applyStimulus(16'h0000, 16'h1234, 0, 0, 0);
    applyStimulus(16'h1234, 16'h0000, 0, 0, 0);
    applyStimulus(16'h0007, 16'h0009, 10, 49, 0);
    checkOutput("lo_7x9", {16'b0, product_lo}, 32'h0000_003F);
    applyStimulus(16'h00FF, 16'h0101, 0, 0, 0);
    applyStimulus(16'hABCD, 16'h1357, 0, 0, 20);
    applyStimulus(16'h0011, 16'h0022, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(16'($urandom), 16'($urandom), 0, 0, 0);
    end
    applyStimulus(16'h8000, 16'h8000, 0, 0, 0);
    applyStimulus(16'hFFFF, 16'h0001, 0, 0, 0);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/k16_mul_seq.md
# k16_mul_seq

Multi-cycle 16x16 multiply sequencer that reuses the shared K16 ALU through its operand/operation/flag interface. It runs shift-and-add, driving ALU ADD and ROR operations for 48 cycles, and returns a 32-bit product. It sits beside the ALU in the K16 core and owns the ALU only while `busy` is high. The parent muxes the ALU inputs to this block while `busy` is high.

## Interface
- WIDTH, 16, operand width; only 16 is supported, and the parameter exists for documentation.
- ITERS, 16, number of multiplier bits processed; must equal WIDTH.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `multiplicand`  in  16  M operand, latched on accept.
- `multiplier`  in  16  Q operand, latched on accept.
- `signed_op`  in  1  two's-complement mode; exists only with K16_MUL_SIGNED_EN.
- `busy`  out  1  high from the cycle after accept through the last compute cycle.
- `done`  out  1  one-cycle pulse; product valid.
- `product_hi`  out  16  upper product word, held until the next accept.
- `product_lo`  out  16  lower product word, held until the next accept.
- `alu_operand1`, `alu_operand2`  out  16  ALU operands.
- `alu_carry_in`  out  1  ALU carry input.
- `alu_operation_type`  out  2  ALU operation type.
- `alu_operation`  out  3  ALU operation.
- `alu_result`  in  16  ALU result.
- `alu_carry_out`  in  1  ALU carry output.
- `alu_zero_out`, `alu_negative_out`  in  1  ALU flags; not used.

## Operation
- Registers: A (accumulator, 16 bits), Q (16 bits), M (16 bits), C (1 bit), count (5 bits), state.
- Reset value of every output and register is 0, with state = IDLE.
- State IDLE: on `start`, latch M and Q, clear A, C and count, then go to ADD. Otherwise stay in IDLE.
- State ADD:
  - If Q[0]=1: drive type ALU_OP, op ADD, operand1=A, operand2=M, carry_in=0, then A<=result and C<=carry_out.
  - If Q[0]=0: C<=0 and A is unchanged; the ALU drive is still ADD.
  - Next state is SHA.
- State SHA: drive SHIFT_OP ROR with operand1=A and carry_in=C, then A<=result and C<=carry_out (the old A[0]). Next state is SHQ.
- State SHQ: drive SHIFT_OP ROR with operand1=Q and carry_in=C, then Q<=result and count<=count+1. If count==ITERS-1, go to DONE; otherwise go to ADD.
- State DONE: `done`=1, product_hi<=A, product_lo<=Q. Next state is IDLE.
- The product registers update only on the DONE edge, so they hold the old value through the whole run.
- Arithmetic: the ADD carry plus the ROR chain forms a 33-bit right shift of {C,A,Q}. This makes the result exact for all unsigned inputs, so no overflow is possible.
- ALU drive in IDLE and DONE: ALU_OP/ADD with zero operands. The parent must not depend on ALU output in these states.
- `start` while busy or in DONE is ignored. It is not queued.
- `reset` mid-operation aborts immediately to IDLE with all outputs 0. No `done` is produced for the aborted run.

## Timing
- Accept edge is E0.
- ADD/SHA/SHQ occupy cycles 1..48, with `busy`=1 in those cycles.
- DONE is cycle 49: `done`=1, `busy`=0. Products are readable from cycle 50 onward. They are also readable in cycle 49, because the product registers load on the edge entering DONE.
- The earliest next accept is the edge ending cycle 50 (state IDLE).
- Latency is fixed and independent of data: 49 cycles from accept to `done` in unsigned mode.
- ALU outputs are combinational from state and registers. ALU results are captured on the same edge; there is no pipeline.

## Configuration
- Macro K16_MUL_SIGNED_EN.
- Defined:
  - Adds the `signed_op` port and states NEGM and NEGQ (before ADD) and NEGL and NEGH (after the last SHQ, before DONE).
  - These states are entered only when `signed_op`=1 on accept; the latched sign flag is S = M[15]^Q[15].
  - NEGM: ALU SUB operand1=0, operand2=M; M<=result only if M[15].
  - NEGQ: the same negation applied to Q.
  - NEGL: SUB 0-Q; C<=carry_out (borrow); Q<=result if S.
  - NEGH: SBC 0-A with carry_in=C; A<=result if S.
  - Signed latency is a fixed 53 cycles.
- Undefined: no port and no states; unsigned only; latency 49.

## Structure
- Package `k16_alu_pkg`:
  - ALU operation-type encodings ALU/SHIFT/LOAD = 00/01/10.
  - Operation encodings ADD=000, SUB=010, SBC=011, ROR=011.
  - The sequencer state enum.
- No sub-module: FSM and registers fit in one module.
- The K16 ALU instance is external, in the parent and in the bench.

## Test plan
- Unsigned 0x0003 × 0x0005 -> `done` exactly 49 cycles after accept; hi=0x0000, lo=0x000F; `busy` high for cycles 1..48.
- 0xFFFF × 0xFFFF -> hi=0xFFFE, lo=0x0001 (exercises ADD carry into the ROR chain).
- 0x0000 × 0x1234, then 0x1234 × 0x0000 -> both give 0x00000000; latency is still 49.
- `start` pulsed at cycles 10 and 49 during a 0x0007 × 0x0009 run -> ignored; single `done` with lo=0x003F; a new `start` at cycle 50 is accepted.
- Assert `reset` at cycle 20 of a run -> `busy`, `done` and products are 0 immediately; no `done` follows; the next run completes normally.
- With K16_MUL_SIGNED_EN:
  - signed 0xFFFD (−3) × 0x0005 -> hi=0xFFFF, lo=0xFFF1 at cycle 53.
  - 0x8000 × 0x8000 signed -> hi=0x4000, lo=0x0000.
